// File: rtl/tile_queue_manager.sv
// Active-tile store with a preview queue, a swap-once hold slot and a five-step
// move-availability judge that probes the matrix memory one direction per cycle.
module tile_queue_manager #(
    parameter int tile_dim_p      = 4,
    parameter int preview_depth_p = 3,
    parameter int scene_width_p   = 10,
    parameter int scene_height_p  = 20,
    parameter int spawn_x_p       = 3,
    parameter int spawn_y_p       = 0,
    localparam int XW   = $clog2(scene_width_p),
    localparam int YW   = $clog2(scene_height_p),
    localparam int SW   = tile_dim_p * tile_dim_p,
    localparam int MW   = $clog2(tile_dim_p),
    localparam int CNTW = (preview_depth_p > 1) ? $clog2(preview_depth_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       empty_i,
    input  logic                       fetch_next_i,
    input  logic                       hold_i,
    input  logic [2:0]                 tile_type_i,
    input  logic [1:0]                 tile_angle_i,
    input  logic                       tile_type_v_i,
    input  logic [XW-1:0]              pos_x_i,
    input  logic [YW-1:0]              pos_y_i,
    input  logic                       pos_v_i,
    output logic [XW-1:0]              pos_x_o,
    output logic [YW-1:0]              pos_y_o,
    output logic [SW-1:0]              shape_o,
    output logic [2:0]                 type_o,
    output logic [1:0]                 angle_o,
    output logic                       is_empty_o,
    output logic [3*preview_depth_p-1:0]  preview_type_o,
    output logic [2*preview_depth_p-1:0]  preview_angle_o,
    output logic [SW*preview_depth_p-1:0] preview_shape_o,
    output logic [2:0]                 hold_type_o,
    output logic                       hold_allowed_o,
    output logic [4:0]                 move_avail_o,
    output logic                       tile_in_game_area_o,
    output logic                       ready_o,
    output logic [XW-1:0]              mm_x_o,
    output logic [YW-1:0]              mm_y_o,
    input  logic [SW-1:0]              mm_data_i,
    output logic [4:0]                 rom_addr_o,
    input  logic [SW-1:0]              rom_shape_i,
    input  logic [MW-1:0]              rom_min_y_i,
    input  logic [4:0]                 random_i
);

    typedef enum logic [3:0] {
        S_FILL, S_IDLE, S_POP, S_HOLD, S_JL, S_JR, S_JD, S_JCW, S_JCCW
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] fill_cnt_q, fill_cnt_d;
    logic [2:0]      type_q, type_d;
    logic [1:0]      angle_q, angle_d;
    logic [XW-1:0]   pos_x_q, pos_x_d;
    logic [YW-1:0]   pos_y_q, pos_y_d;
    logic [SW-1:0]   shape_q, shape_d;
    logic [MW-1:0]   min_y_q, min_y_d;
    logic            in_area_q, in_area_d;
    logic [4:0]      move_q, move_d;
    logic [2:0]      hold_q, hold_d;
    logic            hold_ok_q, hold_ok_d;

    logic [2:0]      q_type_q  [preview_depth_p];
    logic [2:0]      q_type_d  [preview_depth_p];
    logic [1:0]      q_angle_q [preview_depth_p];
    logic [1:0]      q_angle_d [preview_depth_p];
    logic [SW-1:0]   q_shape_q [preview_depth_p];
    logic [SW-1:0]   q_shape_d [preview_depth_p];
    logic [MW-1:0]   q_miny_q  [preview_depth_p];
    logic [MW-1:0]   q_miny_d  [preview_depth_p];

    logic [4:0]      rand_w;
    logic            hold_req, kill, do_pop, probe_free;
    logic [SW-1:0]   judge_shape;

    function automatic logic in_area_f(input logic [YW-1:0] y, input logic [MW-1:0] m);
        return ((YW+1)'(y) + (YW+1)'(m)) < (YW+1)'(scene_height_p);
    endfunction

    assign rand_w   = (random_i[4:2] == 3'd0) ? {3'b111, random_i[1:0]} : random_i;
    assign hold_req = hold_i && hold_ok_q && (type_q != 3'd0);
    assign kill     = empty_i && (state_q != S_FILL);

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_FILL;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (fill_cnt_q == CNTW'(preview_depth_p - 1)) state_d = S_IDLE;
            S_IDLE: begin
                if (tile_type_v_i || pos_v_i) state_d = S_JL;
                else if (hold_req)            state_d = S_HOLD;
                else if (fetch_next_i)        state_d = S_POP;
            end
            S_POP, S_HOLD: state_d = S_JL;
            S_JL:    state_d = S_JR;
            S_JR:    state_d = S_JD;
            S_JD:    state_d = S_JCW;
            S_JCW:   state_d = S_JCCW;
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    always_comb begin
        ready_o    = (state_q == S_IDLE);
        mm_x_o     = pos_x_q;
        mm_y_o     = pos_y_q;
        rom_addr_o = {type_q, angle_q};
        case (state_q)
            S_FILL, S_POP: rom_addr_o = rand_w;
            S_HOLD:  rom_addr_o = (hold_q == 3'd0) ? rand_w : {hold_q, 2'b00};
            S_IDLE:  rom_addr_o = {tile_type_i, tile_angle_i};
            S_JL:    mm_x_o = pos_x_q - XW'(1);
            S_JR:    mm_x_o = pos_x_q + XW'(1);
            S_JD:    mm_y_o = pos_y_q + YW'(1);
            S_JCW:   rom_addr_o = {type_q, angle_q + 2'd1};
            S_JCCW:  rom_addr_o = {type_q, angle_q - 2'd1};
            default: ;
        endcase
    end

    // Rotation checks test the ROM's rotated shape at the current position.
    assign judge_shape = (state_q == S_JCW || state_q == S_JCCW) ? rom_shape_i : shape_q;
    assign probe_free  = ~|(mm_data_i & judge_shape);

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        type_d     = type_q;
        angle_d    = angle_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        shape_d    = shape_q;
        min_y_d    = min_y_q;
        in_area_d  = in_area_q;
        move_d     = move_q;
        hold_d     = hold_q;
        hold_ok_d  = hold_ok_q;
        q_type_d   = q_type_q;
        q_angle_d  = q_angle_q;
        q_shape_d  = q_shape_q;
        q_miny_d   = q_miny_q;
        do_pop     = (state_q == S_POP) || (state_q == S_HOLD && hold_q == 3'd0);
        if (kill) begin
            type_d    = '0;
            angle_d   = '0;
            pos_x_d   = '0;
            pos_y_d   = '0;
            shape_d   = '0;
            min_y_d   = '0;
            in_area_d = 1'b0;
            move_d    = '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    q_type_d[fill_cnt_q]  = rand_w[4:2];
                    q_angle_d[fill_cnt_q] = rand_w[1:0];
                    q_shape_d[fill_cnt_q] = rom_shape_i;
                    q_miny_d[fill_cnt_q]  = rom_min_y_i;
                    fill_cnt_d            = fill_cnt_q + CNTW'(1);
                end
                S_IDLE: begin
                    if (tile_type_v_i) begin
                        type_d  = tile_type_i;
                        angle_d = tile_angle_i;
                        shape_d = rom_shape_i;
                        min_y_d = rom_min_y_i;
                    end
                    if (pos_v_i) begin
                        pos_x_d = pos_x_i;
                        pos_y_d = pos_y_i;
                    end
                    if (tile_type_v_i || pos_v_i)
                        in_area_d = in_area_f(pos_v_i ? pos_y_i : pos_y_q,
                                              pos_v_i ? min_y_q : rom_min_y_i);
                end
                S_HOLD: begin
                    if (hold_q != 3'd0) begin
                        type_d  = hold_q;
                        angle_d = 2'd0;
                        shape_d = rom_shape_i;
                        min_y_d = rom_min_y_i;
                    end
                end
                S_JL:    move_d[0] = probe_free;
                S_JR:    move_d[1] = probe_free;
                S_JD:    move_d[2] = probe_free;
                S_JCW:   move_d[3] = probe_free;
                S_JCCW:  move_d[4] = probe_free;
                default: ;
            endcase
            if (do_pop) begin
                type_d  = q_type_q[0];
                angle_d = q_angle_q[0];
                shape_d = q_shape_q[0];
                min_y_d = q_miny_q[0];
                for (int i = 0; i < preview_depth_p - 1; i++) begin
                    q_type_d[i]  = q_type_q[i+1];
                    q_angle_d[i] = q_angle_q[i+1];
                    q_shape_d[i] = q_shape_q[i+1];
                    q_miny_d[i]  = q_miny_q[i+1];
                end
                q_type_d[preview_depth_p-1]  = rand_w[4:2];
                q_angle_d[preview_depth_p-1] = rand_w[1:0];
                q_shape_d[preview_depth_p-1] = rom_shape_i;
                q_miny_d[preview_depth_p-1]  = rom_min_y_i;
            end
            if (state_q == S_POP) hold_ok_d = 1'b1;
            if (state_q == S_HOLD) begin
                hold_d    = type_q;
                hold_ok_d = 1'b0;
            end
            if (state_q == S_POP || state_q == S_HOLD) begin
                pos_x_d   = XW'(spawn_x_p);
                pos_y_d   = YW'(spawn_y_p);
                in_area_d = in_area_f(YW'(spawn_y_p), min_y_d);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fill_cnt_q <= '0;
            type_q     <= '0;
            angle_q    <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            shape_q    <= '0;
            min_y_q    <= '0;
            in_area_q  <= 1'b0;
            move_q     <= '0;
            hold_q     <= '0;
            hold_ok_q  <= 1'b1;
            for (int i = 0; i < preview_depth_p; i++) begin
                q_type_q[i]  <= '0;
                q_angle_q[i] <= '0;
                q_shape_q[i] <= '0;
                q_miny_q[i]  <= '0;
            end
        end else begin
            fill_cnt_q <= fill_cnt_d;
            type_q     <= type_d;
            angle_q    <= angle_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            shape_q    <= shape_d;
            min_y_q    <= min_y_d;
            in_area_q  <= in_area_d;
            move_q     <= move_d;
            hold_q     <= hold_d;
            hold_ok_q  <= hold_ok_d;
            q_type_q   <= q_type_d;
            q_angle_q  <= q_angle_d;
            q_shape_q  <= q_shape_d;
            q_miny_q   <= q_miny_d;
        end
    end

    generate
        for (genvar gi = 0; gi < preview_depth_p; gi++) begin : g_preview
            assign preview_type_o[gi*3 +: 3]    = q_type_q[gi];
            assign preview_angle_o[gi*2 +: 2]   = q_angle_q[gi];
            assign preview_shape_o[gi*SW +: SW] = q_shape_q[gi];
        end
    endgenerate

    assign pos_x_o             = pos_x_q;
    assign pos_y_o             = pos_y_q;
    assign shape_o             = shape_q;
    assign type_o              = type_q;
    assign angle_o             = angle_q;
    assign is_empty_o          = (type_q == 3'd0);
    assign hold_type_o         = hold_q;
    assign hold_allowed_o      = hold_ok_q;
    assign move_avail_o        = move_q;
    assign tile_in_game_area_o = in_area_q;

endmodule

// File: tb/tb_tile_queue_manager.sv
// Scoreboard bench for tile_queue_manager: a reference model predicts each
// transaction's outcome, which is compared once ready_o returns.
module tb_tile_queue_manager;

    localparam int XW = 4, YW = 5, SW = 16, MW = 2, D = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_i = 1'b1, empty_i = 1'b0, fetch_next_i = 1'b0, hold_i = 1'b0;
    logic [2:0]      tile_type_i = '0;
    logic [1:0]      tile_angle_i = '0;
    logic            tile_type_v_i = 1'b0, pos_v_i = 1'b0;
    logic [XW-1:0]   pos_x_i = '0;
    logic [YW-1:0]   pos_y_i = '0;
    logic [4:0]      random_i = 5'b00010;
    logic [XW-1:0]   pos_x_o, mm_x_o;
    logic [YW-1:0]   pos_y_o, mm_y_o;
    logic [SW-1:0]   shape_o, mm_data_i, rom_shape_i;
    logic [2:0]      type_o, hold_type_o;
    logic [1:0]      angle_o;
    logic            is_empty_o, hold_allowed_o, tile_in_game_area_o, ready_o;
    logic [3*D-1:0]  preview_type_o;
    logic [2*D-1:0]  preview_angle_o;
    logic [SW*D-1:0] preview_shape_o;
    logic [4:0]      move_avail_o, rom_addr_o;
    logic [MW-1:0]   rom_min_y_i;

    tile_queue_manager dut (
        .clk_i(clk), .reset_i(reset_i), .empty_i(empty_i), .fetch_next_i(fetch_next_i),
        .hold_i(hold_i), .tile_type_i(tile_type_i), .tile_angle_i(tile_angle_i),
        .tile_type_v_i(tile_type_v_i), .pos_x_i(pos_x_i), .pos_y_i(pos_y_i), .pos_v_i(pos_v_i),
        .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .shape_o(shape_o), .type_o(type_o),
        .angle_o(angle_o), .is_empty_o(is_empty_o), .preview_type_o(preview_type_o),
        .preview_angle_o(preview_angle_o), .preview_shape_o(preview_shape_o),
        .hold_type_o(hold_type_o), .hold_allowed_o(hold_allowed_o),
        .move_avail_o(move_avail_o), .tile_in_game_area_o(tile_in_game_area_o),
        .ready_o(ready_o), .mm_x_o(mm_x_o), .mm_y_o(mm_y_o), .mm_data_i(mm_data_i),
        .rom_addr_o(rom_addr_o), .rom_shape_i(rom_shape_i), .rom_min_y_i(rom_min_y_i),
        .random_i(random_i)
    );

    // ROM: tile row nibble {1,type} placed in row <angle>; min_y = angle.
    function automatic logic [SW-1:0] rom_shape_f(input logic [4:0] a);
        logic [SW-1:0] s;
        s = '0;
        if (a[4:2] != 3'd0) s = SW'({1'b1, a[4:2]}) << (4 * int'(a[1:0]));
        return s;
    endfunction

    function automatic logic [MW-1:0] rom_miny_f(input logic [4:0] a);
        return (a[4:2] == 3'd0) ? 2'd0 : a[1:0];
    endfunction

    assign rom_shape_i = rom_shape_f(rom_addr_o);
    assign rom_min_y_i = rom_miny_f(rom_addr_o);

    // Matrix memory: out-of-range cells occupied, optional blocked window at (rot_x, rot_y).
    logic          rot_en = 1'b0;
    logic [XW-1:0] rot_x = '0;
    logic [YW-1:0] rot_y = '0;
    logic [SW-1:0] rot_mask = '0;
    always_comb begin
        mm_data_i = '0;
        if (int'(mm_x_o) >= 10 || int'(mm_y_o) >= 20) mm_data_i = '1;
        else if (rot_en && mm_x_o == rot_x && mm_y_o == rot_y) mm_data_i = rot_mask;
    end

    int checks = 0, failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [2:0]    m_type = '0, m_hold = '0;
    logic [1:0]    m_angle = '0;
    logic [XW-1:0] m_x = '0;
    logic [YW-1:0] m_y = '0;
    logic [MW-1:0] m_miny = '0;
    logic          m_in = 1'b0, m_hok = 1'b1;
    logic [2:0]    mq_t [D];
    logic [1:0]    mq_a [D];

    typedef struct {
        logic [2:0] typ; logic [1:0] ang; logic [XW-1:0] x; logic [YW-1:0] y;
        logic [SW-1:0] shape; logic [4:0] mv; logic inarea; logic [2:0] hold; logic hok;
        logic [3*D-1:0] qt; logic [2*D-1:0] qa; logic [SW*D-1:0] qs; int lat;
    } exp_t;
    exp_t sb[$];

    function automatic logic [4:0] remap_f(input logic [4:0] r);
        if (r[4:2] == 3'd0) return {3'b111, r[1:0]};
        return r;
    endfunction

    function automatic logic in_area_f(input logic [YW-1:0] y, input logic [MW-1:0] m);
        return (int'(y) + int'(m)) < 20;
    endfunction

    task automatic m_pop(input logic [4:0] r);
        logic [4:0] w;
        w = remap_f(r);
        m_type  = mq_t[0];
        m_angle = mq_a[0];
        m_miny  = rom_miny_f({mq_t[0], mq_a[0]});
        for (int i = 0; i < D - 1; i++) begin
            mq_t[i] = mq_t[i+1];
            mq_a[i] = mq_a[i+1];
        end
        mq_t[D-1] = w[4:2];
        mq_a[D-1] = w[1:0];
        m_x = 4'd3;
        m_y = 5'd0;
        m_in = in_area_f(m_y, m_miny);
    endtask

    task automatic m_clear();
        m_type = '0; m_angle = '0; m_x = '0; m_y = '0; m_miny = '0; m_in = 1'b0;
    endtask

    task automatic push_exp(input int lat, input logic [4:0] mv);
        exp_t e;
        e.typ = m_type; e.ang = m_angle; e.x = m_x; e.y = m_y;
        e.shape = rom_shape_f({m_type, m_angle});
        e.mv = mv; e.inarea = m_in; e.hold = m_hold; e.hok = m_hok; e.lat = lat;
        for (int i = 0; i < D; i++) begin
            e.qt[i*3 +: 3]   = mq_t[i];
            e.qa[i*2 +: 2]   = mq_a[i];
            e.qs[i*SW +: SW] = rom_shape_f({mq_t[i], mq_a[i]});
        end
        sb.push_back(e);
    endtask

    // Entered on a negedge with the request already driven; returns on the negedge where ready_o is high.
    task automatic finish_txn(input string name);
        int lat;
        exp_t e;
        @(negedge clk);
        reset_i = 1'b0; fetch_next_i = 1'b0; hold_i = 1'b0; tile_type_v_i = 1'b0;
        pos_v_i = 1'b0; empty_i = 1'b0;
        lat = 0;
        while (!ready_o && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        e = sb.pop_front();
        $display("TXN %s lat=%0d type=%0d angle=%0d pos=(%0d,%0d) move=%b in_area=%0d hold=%0d",
                 name, lat, type_o, angle_o, pos_x_o, pos_y_o, move_avail_o,
                 tile_in_game_area_o, hold_type_o);
        check_val({name, ".latency"}, lat, e.lat);
        check_val({name, ".type"}, type_o, e.typ);
        check_val({name, ".angle"}, angle_o, e.ang);
        check_val({name, ".pos_x"}, pos_x_o, e.x);
        check_val({name, ".pos_y"}, pos_y_o, e.y);
        check_val({name, ".shape"}, shape_o, e.shape);
        check_val({name, ".is_empty"}, is_empty_o, (e.typ == 3'd0));
        check_val({name, ".move"}, move_avail_o, e.mv);
        check_val({name, ".in_area"}, tile_in_game_area_o, e.inarea);
        check_val({name, ".hold"}, hold_type_o, e.hold);
        check_val({name, ".hold_ok"}, hold_allowed_o, e.hok);
        check_val({name, ".q_type"}, preview_type_o, e.qt);
        check_val({name, ".q_angle"}, preview_angle_o, e.qa);
        check_val({name, ".q_shape"}, preview_shape_o, e.qs);
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            mq_t[i] = '0;
            mq_a[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_val("reset.ready", ready_o, 1'b0);
        check_val("reset.is_empty", is_empty_o, 1'b1);
        check_val("reset.hold_ok", hold_allowed_o, 1'b1);
        check_val("reset.hold", hold_type_o, 3'd0);
        check_val("reset.move", move_avail_o, 5'd0);
        check_val("reset.in_area", tile_in_game_area_o, 1'b0);
        check_val("reset.q_type", preview_type_o, '0);

        // Fill: random 00010 remaps to type 7, angle 2
        for (int i = 0; i < D; i++) begin
            mq_t[i] = 3'd7;
            mq_a[i] = 2'd2;
        end
        push_exp(3, 5'd0);
        finish_txn("fill");

        random_i = 5'b01001;
        m_pop(random_i); m_hok = 1'b1;
        push_exp(6, 5'b11111);
        fetch_next_i = 1'b1;
        finish_txn("fetch1");

        pos_x_i = 4'd0; pos_y_i = 5'd5; pos_v_i = 1'b1;
        m_x = 4'd0; m_y = 5'd5; m_in = in_area_f(m_y, m_miny);
        push_exp(5, 5'b11110);
        finish_txn("pos_left_edge");

        // Block only the footprint of the CW-rotated tile (row 2) at (4,5)
        rot_en = 1'b1; rot_x = 4'd4; rot_y = 5'd5; rot_mask = 16'h0F00;
        tile_type_i = 3'd3; tile_angle_i = 2'd1; tile_type_v_i = 1'b1;
        pos_x_i = 4'd4; pos_y_i = 5'd5; pos_v_i = 1'b1;
        m_in = in_area_f(5'd5, m_miny);
        m_type = 3'd3; m_angle = 2'd1; m_miny = 2'd1; m_x = 4'd4; m_y = 5'd5;
        push_exp(5, 5'b10111);
        finish_txn("rotate_block");
        rot_en = 1'b0;

        pos_x_i = 4'd0; pos_y_i = 5'd19; pos_v_i = 1'b1;
        m_x = 4'd0; m_y = 5'd19; m_in = in_area_f(m_y, m_miny);
        push_exp(5, 5'b11010);
        finish_txn("pos_bottom");

        random_i = 5'b10111;
        m_hold = m_type; m_pop(random_i); m_hok = 1'b0;
        push_exp(6, 5'b11111);
        hold_i = 1'b1;
        finish_txn("hold_empty");

        push_exp(0, 5'b11111);
        hold_i = 1'b1;
        finish_txn("hold_denied");

        random_i = 5'b00001;
        m_pop(random_i); m_hok = 1'b1;
        push_exp(6, 5'b11111);
        fetch_next_i = 1'b1;
        finish_txn("fetch2");

        begin
            logic [2:0] held;
            held = m_hold;
            m_hold = m_type;
            m_type = held; m_angle = 2'd0; m_miny = rom_miny_f({held, 2'd0});
            m_x = 4'd3; m_y = 5'd0; m_in = in_area_f(m_y, m_miny); m_hok = 1'b0;
        end
        push_exp(6, 5'b11111);
        hold_i = 1'b1;
        finish_txn("hold_swap");

        // Start a position update, then kill it two cycles into the judge sequence
        pos_x_i = 4'd2; pos_y_i = 5'd2; pos_v_i = 1'b1;
        @(negedge clk);
        pos_v_i = 1'b0;
        @(negedge clk);
        m_clear();
        push_exp(0, 5'd0);
        empty_i = 1'b1; fetch_next_i = 1'b1;
        finish_txn("empty_mid_judge");
        repeat (6) @(negedge clk);
        check_val("empty_stays.ready", ready_o, 1'b1);
        check_val("empty_stays.type", type_o, 3'd0);

        random_i = 5'b11000;
        m_pop(random_i); m_hok = 1'b1;
        push_exp(6, 5'b11111);
        fetch_next_i = 1'b1;
        finish_txn("fetch3");

        m_clear();
        push_exp(0, 5'd0);
        empty_i = 1'b1;
        finish_txn("empty_idle");

        push_exp(0, 5'd0);
        hold_i = 1'b1;
        finish_txn("hold_on_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
